// File: rtl/mcdp_pkg.sv
// Shared constants for the multi-cycle datapath: opcodes, FSM state
// encoding and instruction field positions.
package mcdp_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RS_HI = 11;
    localparam int RS_LO = 8;
    localparam int RT_HI = 7;
    localparam int RT_LO = 4;
    localparam int RD_HI = 3;
    localparam int RD_LO = 0;

    // Ops whose second ALU operand is the zero-extended 4-bit immediate.
    function automatic logic uses_imm(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mcdp_alu.sv
// Combinational ALU for the multi-cycle datapath. Compare flags are always
// the unsigned relation of a vs b; ops without an arithmetic result
// (JMP, NOP, HALT) produce result 0 and cout 0.
module mcdp_alu
    import mcdp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              lt,
    output logic              eq,
    output logic              gt
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

    // Result/carry select by opcode; BEQ reuses the subtractor.
    always_comb begin
        result = '0;
        cout   = 1'b0;
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: begin
                result = sum[DATA_W-1:0];
                cout   = sum[DATA_W];
            end
            OP_SUB, OP_BEQ: begin
                result = diff[DATA_W-1:0];
                cout   = diff[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
            default: result = '0;
        endcase
    end

    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle datapath: PC, IR, 16-entry register file, data memory and
// FSM sequencing of fetch/decode/execute/memory/writeback.
// Optional feature macro: SINGLE_STEP_EN (adds `step`, gating FETCH).
//
//  state  | meaning
//  IDLE   | waiting for start
//  FETCH  | IR <= instr_data, PC <= PC+1 (gated by step when single-stepping)
//  DECODE | A <= R[rs], B <= R[rt]
//  EXEC   | ALU result/flags registered; BEQ/JMP update PC
//  MEM    | SW writes data memory; LW registers the read word
//  WB     | register file write, wb_en pulse
//  HALT   | stopped until clear
module multicycle_datapath
    import mcdp_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int PC_W       = 8,
    parameter int DMEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [PC_W-1:0]   instr_addr,
    input  logic [15:0]       instr_data,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] alu_out,
    output logic              lt,
    output logic              eq,
    output logic              gt,
    output logic              cout,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              halted
);

    localparam int DA_W = $clog2(DMEM_DEPTH);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [PC_W-1:0]   pc_q;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [3:0]        op;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [3:0]        rd;
    logic [3:0]        dest;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cout;
    logic              alu_lt;
    logic              alu_eq;
    logic              alu_gt;
    logic [PC_W-1:0]   br_off;
    logic [PC_W-1:0]   jmp_target;
    logic [DATA_W-1:0] wb_val;
    logic [DA_W-1:0]   dmem_addr;
    logic              fetch_go;

`ifdef SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    assign op   = ir[OP_HI:OP_LO];
    assign rs   = ir[RS_HI:RS_LO];
    assign rt   = ir[RT_HI:RT_LO];
    assign rd   = ir[RD_HI:RD_LO];
    assign dest = (op <= OP_SLT) ? rd : rt;

    assign op_b       = uses_imm(op) ? {{(DATA_W-4){1'b0}}, rd} : b_q;
    assign br_off     = {{(PC_W-4){rd[3]}}, rd};
    assign jmp_target = PC_W'(ir[RS_HI:0]);
    assign dmem_addr  = alu_out[DA_W-1:0];

    mcdp_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (a_q),
        .b      (op_b),
        .result (alu_res),
        .cout   (alu_cout),
        .lt     (alu_lt),
        .eq     (alu_eq),
        .gt     (alu_gt)
    );

    // Next-state sequencing; the path out of EXEC depends on the opcode.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_FETCH;
            ST_FETCH:  if (fetch_go) state_nx = ST_DECODE;
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC: begin
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI:
                        state_nx = ST_WB;
                    OP_LW, OP_SW: state_nx = ST_MEM;
                    OP_HALT:      state_nx = ST_HALT;
                    default:      state_nx = ST_FETCH;
                endcase
            end
            ST_MEM:    state_nx = (op == OP_LW) ? ST_WB : ST_FETCH;
            ST_WB:     state_nx = ST_FETCH;
            ST_HALT:   state_nx = ST_HALT;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Architectural state: FSM, PC, IR, operand latches, ALU result/flags, registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state   <= ST_IDLE;
            pc_q    <= '0;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
            cout    <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_FETCH: begin
                    if (fetch_go) begin
                        ir   <= instr_data;
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                ST_DECODE: begin
                    a_q <= regs[rs];
                    b_q <= regs[rt];
                end
                ST_EXEC: begin
                    alu_out <= alu_res;
                    cout    <= alu_cout;
                    lt      <= alu_lt;
                    eq      <= alu_eq;
                    gt      <= alu_gt;
                    if (op == OP_BEQ && alu_eq) pc_q <= pc_q + br_off;
                    if (op == OP_JMP)           pc_q <= jmp_target;
                end
                ST_WB: begin
                    if (wb_en) regs[dest] <= wb_val;
                end
                default: ;
            endcase
        end
    end

    // Data memory is not reset; clear held at an edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!clear && state == ST_MEM) begin
            if (op == OP_SW) dmem[dmem_addr] <= b_q;
            mdr <= dmem[dmem_addr];
        end
    end

    assign wb_val     = (op == OP_LW) ? mdr : alu_out;
    assign wb_en      = (state == ST_WB) && (dest != 4'd0);
    assign wb_addr    = wb_en ? dest : 4'd0;
    assign wb_data    = wb_en ? wb_val : '0;
    assign pc         = pc_q;
    assign instr_addr = pc_q;
    assign busy       = (state != ST_IDLE) && (state != ST_HALT);
    assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: an instruction-level model predicts every
// cycle's outputs from the ISA rules and per-op cycle counts; directed
// programs pin the model with literal values.
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic        step;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data;
    logic [7:0]  pc;
    logic [15:0] alu_out;
    logic        lt, eq, gt, cout;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy, halted;

    logic [15:0] imem [256];
    assign instr_data = imem[instr_addr];

    always #5 clk = ~clk;

    multicycle_datapath #(.DATA_W(16), .PC_W(8), .DMEM_DEPTH(16)) dut (
        .clk        (clk),
        .clear      (clear),
        .start      (start),
`ifdef SINGLE_STEP_EN
        .step       (step),
`endif
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .pc         (pc),
        .alu_out    (alu_out),
        .lt         (lt),
        .eq         (eq),
        .gt         (gt),
        .cout       (cout),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .busy       (busy),
        .halted     (halted)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Writeback and PC-change log, used by the directed literal checks.
    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [15:0] alu;
        logic        c;
        logic        l;
    } wb_ev_t;

    wb_ev_t     wlog [$];
    logic [7:0] pcq [$];
    logic [7:0] last_pc;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wb_ev_t e;
        if (wb_en === 1'b1) begin
            e.cyc = cyc; e.addr = wb_addr; e.data = wb_data;
            e.alu = alu_out; e.c = cout; e.l = lt;
            wlog.push_back(e);
        end
        if (pc !== last_pc) begin
            pcq.push_back(pc);
            last_pc = pc;
        end
    end

    // Instruction-level reference state.
    logic [15:0] m_reg [16];
    logic [15:0] m_mem [16];
    logic [7:0]  m_pc;
    logic [15:0] m_alu;
    logic        m_lt, m_eq, m_gt, m_cout;

    function automatic int n_cycles(input logic [3:0] op);
        if (op <= 4'd6) return 4;
        if (op == 4'd7) return 5;
        if (op == 4'd8) return 4;
        return 3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'd0;
        m_pc = 8'd0; m_alu = 16'd0;
        m_lt = 1'b0; m_eq = 1'b0; m_gt = 1'b0; m_cout = 1'b0;
    endtask

    // Execute one instruction in the model and check the DUT on each of its cycles.
    task automatic do_instr(output bit halt_seen);
        logic [15:0] ir, a, b, res, wval;
        logic [3:0]  op, dest;
        logic [7:0]  pc_inc, pc_nx, e_pc;
        logic        c, wr, wbe, e_old;
        int          nc, imm_s;
        ir = imem[m_pc];
        op = ir[15:12];
        a  = m_reg[ir[11:8]];
        b  = (op == 4'd6 || op == 4'd7 || op == 4'd8) ? {12'd0, ir[3:0]} : m_reg[ir[7:4]];
        c = 1'b0; res = 16'd0;
        case (op)
            4'd0, 4'd6, 4'd7, 4'd8: {c, res} = {1'b0, a} + {1'b0, b};
            4'd1, 4'd9: begin res = a - b; c = (a >= b); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = (a < b) ? 16'd1 : 16'd0;
            default: ;
        endcase
        pc_inc = m_pc + 8'd1;
        pc_nx  = pc_inc;
        imm_s  = ir[3] ? int'(ir[3:0]) - 16 : int'(ir[3:0]);
        if (op == 4'd9 && a == b) pc_nx = 8'(int'(pc_inc) + imm_s);
        if (op == 4'd10) pc_nx = ir[7:0];
        wr   = (op <= 4'd7);
        dest = (op <= 4'd5) ? ir[3:0] : ir[7:4];
        wval = (op == 4'd7) ? m_mem[res[3:0]] : res;
        nc   = n_cycles(op);
        for (int k = 0; k < nc; k++) begin
            @(negedge clk);
            e_pc  = (k == 0) ? m_pc : ((k <= 2) ? pc_inc : pc_nx);
            e_old = (k <= 2);
            wbe   = (k == nc - 1) && wr && (dest != 4'd0);
            chk("pc", pc, e_pc);
            chk("instr_addr", instr_addr, e_pc);
            chk("alu_out", alu_out, e_old ? m_alu : res);
            chk("cout", cout, e_old ? m_cout : c);
            chk("lt", lt, e_old ? m_lt : (a < b));
            chk("eq", eq, e_old ? m_eq : (a == b));
            chk("gt", gt, e_old ? m_gt : (a > b));
            chk("wb_en", wb_en, wbe);
            chk("wb_addr", wb_addr, wbe ? dest : 4'd0);
            chk("wb_data", wb_data, wbe ? wval : 16'd0);
            chk("busy", busy, 1'b1);
            chk("halted", halted, 1'b0);
        end
        if (wr && dest != 4'd0) m_reg[dest] = wval;
        if (op == 4'd8) m_mem[res[3:0]] = m_reg[ir[7:4]];
        m_pc = pc_nx; m_alu = res; m_cout = c;
        m_lt = (a < b); m_eq = (a == b); m_gt = (a > b);
        halt_seen = (op == 4'hF);
    endtask

    task automatic run_program(input int limit);
        bit h;
        int n;
        @(negedge clk);
        #1;
        wlog.delete();
        pcq.delete();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        h = 1'b0; n = 0;
        while (!h && n < limit) begin
            do_instr(h);
            n++;
        end
        if (h) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                start = (k == 1);
                chk("halt_halted", halted, 1'b1);
                chk("halt_busy", busy, 1'b0);
                chk("halt_pc", pc, m_pc);
                chk("halt_alu", alu_out, m_alu);
                chk("halt_wb_en", wb_en, 1'b0);
            end
            start = 1'b0;
        end
    endtask

    // Caller positions at a negedge first.
    task automatic do_clear();
        clear = 1'b1;
        #1;
        chk("clr_pc", pc, 8'd0);
        chk("clr_instr_addr", instr_addr, 8'd0);
        chk("clr_alu_out", alu_out, 16'd0);
        chk("clr_flags", {lt, eq, gt, cout}, 4'd0);
        chk("clr_wb_en", wb_en, 1'b0);
        chk("clr_wb_addr", wb_addr, 4'd0);
        chk("clr_wb_data", wb_data, 16'd0);
        chk("clr_busy", busy, 1'b0);
        chk("clr_halted", halted, 1'b0);
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic imem_fill_halt();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] op;
        logic [15:0] w;
        op = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 3) == 0) op = 4'd6;
        w = {op, 12'($urandom)};
        if (op == 4'd10) w[11:0] = 12'($urandom_range(0, 63));
        return w;
    endfunction

    logic [7:0] exp_pcs [16];

    initial begin
        #500000;
        $display("FAIL timeout: bench exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        clear = 1'b0;
        start = 1'b0;
        step  = 1'b1;
        imem_fill_halt();
        @(negedge clk);
        do_clear();

        // Initialise data memory: SW R0 -> M[i] for all 16 words.
        for (int i = 0; i < 16; i++) imem[i] = 16'h8000 | 16'(i);
        run_program(40);

        // Program A: ADDI/ADDI/ADD/SW/LW.
        @(negedge clk);
        do_clear();
        imem_fill_halt();
        imem[0] = 16'h6015; imem[1] = 16'h6023; imem[2] = 16'h0123;
        imem[3] = 16'h8032; imem[4] = 16'h7042;
        run_program(20);
        chk("A_nwb", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("A_addr0", wlog[0].addr, 4'd1); chk("A_data0", wlog[0].data, 16'd5);
            chk("A_addr1", wlog[1].addr, 4'd2); chk("A_data1", wlog[1].data, 16'd3);
            chk("A_addr2", wlog[2].addr, 4'd3); chk("A_data2", wlog[2].data, 16'd8);
            chk("A_addr3", wlog[3].addr, 4'd4); chk("A_data3", wlog[3].data, 16'd8);
            chk("A_add_cycles", wlog[2].cyc - wlog[1].cyc, 4);
            chk("A_sw_lw_cycles", wlog[3].cyc - wlog[2].cyc, 9);
        end
        chk("A_halt_pc", pc, 8'd6);

        // Program B: BEQ taken/not taken, JMP 0x0FF, PC wrap.
        @(negedge clk);
        do_clear();
        imem_fill_halt();
        imem[0] = 16'h9601; imem[1] = 16'hF000; imem[2] = 16'h6017;
        imem[3] = 16'h6027; imem[4] = 16'hA00A; imem[10] = 16'h912E;
        imem[9] = 16'h6026; imem[11] = 16'h6061; imem[12] = 16'hA0FF;
        imem[255] = 16'hB000;
        exp_pcs = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd10, 8'd11, 8'd9,
                    8'd10, 8'd11, 8'd12, 8'd13, 8'd255, 8'd0, 8'd1, 8'd2};
        run_program(40);
        chk("B_npc", pcq.size(), 16);
        for (int i = 0; i < 16 && i < pcq.size(); i++) chk("B_pc_seq", pcq[i], exp_pcs[i]);

        // Program C: SUB underflow, ADD carry, write to R0 discarded.
        @(negedge clk);
        do_clear();
        imem_fill_halt();
        imem[0] = 16'h6011; imem[1] = 16'h1012; imem[2] = 16'h0213;
        imem[3] = 16'h6009; imem[4] = 16'h0014;
        run_program(20);
        chk("C_nwb", wlog.size(), 4);
        if (wlog.size() == 4) begin
            chk("C_sub_alu", wlog[1].alu, 16'hFFFF);
            chk("C_sub_lt", wlog[1].l, 1'b1);
            chk("C_sub_cout", wlog[1].c, 1'b0);
            chk("C_add_alu", wlog[2].alu, 16'h0000);
            chk("C_add_cout", wlog[2].c, 1'b1);
            chk("C_r0_addr", wlog[3].addr, 4'd4);
            chk("C_r0_zero", wlog[3].data, 16'd1);
        end

        // Program D: clear while LW sits in MEM.
        @(negedge clk);
        do_clear();
        imem_fill_halt();
        imem[0] = 16'h7052;
        @(negedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("D_busy_mem", busy, 1'b1);
        chk("D_alu_mem", alu_out, 16'd2);
        do_clear();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("D_after_wb_en", wb_en, 1'b0);
            chk("D_after_busy", busy, 1'b0);
        end

        // Random programs.
        for (int p = 0; p < 8; p++) begin
            imem_fill_halt();
            for (int i = 0; i < 48; i++) imem[i] = rand_instr();
            @(negedge clk);
            do_clear();
            run_program(300);
        end

`ifdef SINGLE_STEP_EN
        imem_fill_halt();
        imem[0] = 16'h6011; imem[1] = 16'h6022; imem[2] = 16'h6033;
        @(negedge clk);
        do_clear();
        step = 1'b0;
        @(negedge clk);
        #1;
        wlog.delete();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        chk("S_pc_wait", pc, 8'd0);
        chk("S_busy_wait", busy, 1'b1);
        chk("S_nwb_wait", wlog.size(), 0);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (6) @(negedge clk);
        end
        chk("S_nwb", wlog.size(), 3);
        chk("S_pc", pc, 8'd3);
        step = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
